// File: rtl/clk_cpu_monitor.sv
// clk_cpu_monitor
// Consumer side of the divided CPU clock. clk_cpu is sampled as ordinary data
// in the clk domain. The block turns it into one-cycle rise/fall ticks, and
// releases rst_cpu only after a fixed number of complete clk_cpu periods. In
// RUN it issues a CPU clock-enable on every rising tick and counts enabled
// cycles. A watchdog returns the block to IDLE, with rst_cpu asserted, if
// clk_cpu stops toggling.
//
// Optional feature macro: STEP_MODE_EN
//   When defined, step_mode/step_req ports are added. While step_mode is high,
//   the CPU advances one cycle for each rising edge of step_req.
//   When undefined, cpu_ce free-runs in RUN.

module clk_cpu_monitor #(
    parameter int RST_CYCLES = 4,    // HOLD rising edges before release, 1..255
    parameter int CNT_W      = 8,    // width of cyc_cnt
    parameter int TIMEOUT    = 64    // clk cycles without a tick before lock is dropped, 2..65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_cpu,
`ifdef STEP_MODE_EN
    input  logic             step_mode,
    input  logic             step_req,
`endif
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             cpu_ce,
    output logic             rst_cpu,
    output logic             locked,
    output logic [CNT_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FIRST_ONE  = 3'd1,
        ST_FIRST_ZERO = 3'd2,
        ST_HOLD       = 3'd3,
        ST_RUN        = 3'd4
    } state_t;

    localparam int              WD_W     = 16;
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};
    localparam logic [7:0]      HOLD_MIN = 8'(RST_CYCLES);

    state_t           state_reg, state_next;
    logic             s0_reg, s1_reg;
    logic             rise_reg, fall_reg;
    logic             cpu_ce_reg, cpu_ce_next;
    logic             rst_cpu_reg, locked_reg;
    logic [CNT_W-1:0] cyc_cnt_reg, cyc_cnt_next;
    logic [7:0]       hold_cnt_reg, hold_cnt_next;
    logic [WD_W-1:0]  wd_cnt_reg, wd_cnt_next;
    logic             tick;
    logic             timeout;
    logic             step_ok;

    // Two-stage sample of clk_cpu, followed by registered edge ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_reg   <= 1'b0;
            s1_reg   <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            s0_reg   <= clk_cpu;
            s1_reg   <= s0_reg;
            rise_reg <= s0_reg & ~s1_reg;
            fall_reg <= ~s0_reg & s1_reg;
        end
    end

    assign tick = rise_reg | fall_reg;

    // A tick in the same cycle always beats the watchdog.
    assign timeout = (state_reg != ST_IDLE) && !tick && (wd_cnt_reg == WD_LAST);

    // Sequencer state and HOLD period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Next-state logic. The CPU must see one complete clk_cpu period
    // (rise, fall, rise) before HOLD starts counting. Release happens on a
    // falling tick, which gives the CPU a half-period of setup margin.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        if (timeout) begin
            state_next    = ST_IDLE;
            hold_cnt_next = 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (rise_reg) state_next = ST_FIRST_ONE;
                end
                ST_FIRST_ONE: begin
                    if (fall_reg) state_next = ST_FIRST_ZERO;
                end
                ST_FIRST_ZERO: begin
                    if (rise_reg) begin
                        state_next    = ST_HOLD;
                        hold_cnt_next = 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (rise_reg) begin
                        hold_cnt_next = hold_cnt_reg + 8'd1;
                    end else if (fall_reg && (hold_cnt_reg >= HOLD_MIN)) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_next = ST_RUN;
                end
                default: begin
                    state_next    = ST_IDLE;
                    hold_cnt_next = 8'd0;
                end
            endcase
        end
    end

    // Watchdog counter: held at zero while idle, restarted by every tick,
    // saturating so that it never wraps back into a false timeout.
    always_comb begin
        wd_cnt_next = wd_cnt_reg;
        if ((state_reg == ST_IDLE) || tick || timeout) begin
            wd_cnt_next = '0;
        end else if (wd_cnt_reg != WD_MAX) begin
            wd_cnt_next = wd_cnt_reg + 16'd1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
        end
    end

`ifdef STEP_MODE_EN
    logic step_req_d_reg;
    logic step_pend_reg, step_pend_next;
    logic step_edge;

    assign step_edge = step_req & ~step_req_d_reg;

    // A pending step is consumed by the next rising tick in RUN. A request
    // edge that arrives while a step is still pending is discarded.
    always_comb begin
        step_pend_next = step_pend_reg;
        if (timeout) begin
            step_pend_next = 1'b0;
        end else if ((state_reg == ST_RUN) && rise_reg && step_pend_reg) begin
            step_pend_next = 1'b0;
        end else if ((state_reg == ST_RUN) && step_mode && step_edge && !step_pend_reg) begin
            step_pend_next = 1'b1;
        end
    end

    // Step request edge detector and pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_req_d_reg <= 1'b0;
            step_pend_reg  <= 1'b0;
        end else begin
            step_req_d_reg <= step_req;
            step_pend_reg  <= step_pend_next;
        end
    end

    assign step_ok = !step_mode || step_pend_reg;
`else
    assign step_ok = 1'b1;
`endif

    // Clock-enable and cycle-counter next values.
    always_comb begin
        cpu_ce_next  = rise_reg && (state_reg == ST_RUN) && step_ok;
        cyc_cnt_next = cyc_cnt_reg;
        if (timeout) begin
            cyc_cnt_next = '0;
        end else if (cpu_ce_reg) begin
            cyc_cnt_next = cyc_cnt_reg + CNT_W'(1);
        end
    end

    // Registered outputs. rst_cpu and locked follow the next state, so they
    // change on the same edge as the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ce_reg  <= 1'b0;
            rst_cpu_reg <= 1'b1;
            locked_reg  <= 1'b0;
            cyc_cnt_reg <= '0;
        end else begin
            cpu_ce_reg  <= cpu_ce_next;
            rst_cpu_reg <= (state_next != ST_RUN);
            locked_reg  <= (state_next == ST_RUN);
            cyc_cnt_reg <= cyc_cnt_next;
        end
    end

    assign rise_tick = rise_reg;
    assign fall_tick = fall_reg;
    assign cpu_ce    = cpu_ce_reg;
    assign rst_cpu   = rst_cpu_reg;
    assign locked    = locked_reg;
    assign cyc_cnt   = cyc_cnt_reg;

endmodule

// File: tb/tb_clk_cpu_monitor.sv
// Testbench for clk_cpu_monitor.
// The reference model works from the sampled clk_cpu history. It treats the
// sequencing as "count rising edges since leaving idle", and the watchdog as
// "cycles elapsed since the last tick". At every clk edge it pushes the events
// expected in that cycle (tick, clock-enable, lock, unlock) into a queue. An
// independent monitor running on negedge pops the queue and compares it with
// whatever the DUT presents.

module tb_clk_cpu_monitor;

    localparam int RST_CYCLES = 4;
    localparam int CNT_W      = 4;
    localparam int TIMEOUT    = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_cpu;
    logic             rise_tick;
    logic             fall_tick;
    logic             cpu_ce;
    logic             rst_cpu;
    logic             locked;
    logic [CNT_W-1:0] cyc_cnt;

    always #5 clk = ~clk;

    clk_cpu_monitor #(
        .RST_CYCLES (RST_CYCLES),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_cpu   (clk_cpu),
`ifdef STEP_MODE_EN
        .step_mode (1'b0),
        .step_req  (1'b0),
`endif
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .cpu_ce    (cpu_ce),
        .rst_cpu   (rst_cpu),
        .locked    (locked),
        .cyc_cnt   (cyc_cnt)
    );

    typedef enum int {EV_RISE, EV_FALL, EV_CE, EV_LOCK, EV_UNLOCK} ev_t;
    typedef struct {
        int  cyc;
        ev_t kind;
        int  val;
    } ev_s;

    ev_s exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    // Reference-model state (in visible-cycle time).
    int  cyc       = 0;
    bit  rst_seen  = 1'b1;
    bit  p1, p2;            // clk_cpu sampled one and two edges ago
    bit  prev_r, prev_f;    // ticks visible in the previous cycle
    int  phase     = 0;     // 0 idle, 1 sequencing, 2 run
    int  rises     = 0;     // rising ticks since leaving idle
    int  last_tick = 0;
    int  cnt       = 0;

    function automatic string ev_name(input ev_t k);
        case (k)
            EV_RISE:  return "rise_tick";
            EV_FALL:  return "fall_tick";
            EV_CE:    return "cpu_ce";
            EV_LOCK:  return "lock";
            default:  return "unlock";
        endcase
    endfunction

    task automatic push_ev(input ev_t k, input int v);
        ev_s e;
        e.cyc  = cyc;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Advance the model over one clk edge, using the inputs sampled at that edge.
    task automatic model_edge();
        bit tr, tf, ce, to, lk, ul;
        cyc++;
        rst_seen = rst;
        if (rst) begin
            p1 = 1'b0; p2 = 1'b0; prev_r = 1'b0; prev_f = 1'b0;
            phase = 0; rises = 0; cnt = 0; last_tick = cyc;
            exp_q.delete();
        end else begin
            tr = p1 & ~p2;
            tf = ~p1 & p2;
            ce = prev_r && (phase == 2);
            to = (phase != 0) && ((cyc - 1 - last_tick) == TIMEOUT);
            lk = 1'b0;
            ul = 1'b0;
            if (to) begin
                ul    = (phase == 2);
                phase = 0;
                rises = 0;
                cnt   = 0;
            end else if (prev_r) begin
                if (phase == 0) begin
                    phase = 1;
                    rises = 1;
                end else if (phase == 1) begin
                    rises++;
                end
            end else if (prev_f) begin
                if ((phase == 1) && (rises >= RST_CYCLES + 1)) begin
                    phase = 2;
                    lk    = 1'b1;
                end
            end
            if (tr) push_ev(EV_RISE, 0);
            if (tf) push_ev(EV_FALL, 0);
            if (ce) begin
                push_ev(EV_CE, cnt);
                cnt = (cnt + 1) % (1 << CNT_W);
            end
            if (lk) push_ev(EV_LOCK, 0);
            if (ul) push_ev(EV_UNLOCK, 0);
            if (tr || tf) last_tick = cyc;
            prev_r = tr;
            prev_f = tf;
            p2 = p1;
            p1 = clk_cpu;
        end
    endtask

    task automatic step(input logic v, input logic r);
        @(posedge clk);
        #1;
        model_edge();
        clk_cpu = v;
        rst     = r;
    endtask

    task automatic hold_level(input logic v, input int n);
        repeat (n) step(v, 1'b0);
    endtask

    task automatic periods(input int n, input int h);
        repeat (n) begin
            hold_level(1'b1, h);
            hold_level(1'b0, h);
        end
    endtask

    task automatic rand_periods(input int n);
        repeat (n) begin
            hold_level(1'b1, $urandom_range(2, 7));
            hold_level(1'b0, $urandom_range(2, 7));
        end
    endtask

    task automatic do_reset(input int n, input logic lvl);
        repeat (n) step(lvl, 1'b1);
    endtask

    task automatic match_ev(input ev_t k, input int v, input bit use_v);
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].kind != k) begin
            failures++;
            $display("FAIL %s cyc=%0d: DUT shows event, required none at this cycle", ev_name(k), cyc);
        end else if (use_v && exp_q[0].val != v) begin
            failures++;
            $display("FAIL %s_cyc_cnt cyc=%0d: cyc_cnt=%0d required %0d", ev_name(k), cyc, v, exp_q[0].val);
            void'(exp_q.pop_front());
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    // Monitor: compares DUT outputs with queued expectations, away from posedge.
    initial begin : monitor
        bit prev_locked;
        prev_locked = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                if (rst_seen) begin
                    checks++;
                    if (rise_tick || fall_tick || cpu_ce || !rst_cpu || locked || cyc_cnt != '0) begin
                        failures++;
                        $display("FAIL reset_state cyc=%0d: rise=%0b fall=%0b ce=%0b rst_cpu=%0b locked=%0b cnt=%0d required 0 0 0 1 0 0",
                                 cyc, rise_tick, fall_tick, cpu_ce, rst_cpu, locked, cyc_cnt);
                    end
                end else begin
                    checks++;
                    if (rst_cpu == locked) begin
                        failures++;
                        $display("FAIL rst_cpu_vs_locked cyc=%0d: rst_cpu=%0b locked=%0b required complementary",
                                 cyc, rst_cpu, locked);
                    end
                    if (rise_tick) match_ev(EV_RISE, 0, 1'b0);
                    if (fall_tick) match_ev(EV_FALL, 0, 1'b0);
                    if (cpu_ce) match_ev(EV_CE, int'(cyc_cnt), 1'b1);
                    if (locked && !prev_locked) match_ev(EV_LOCK, 0, 1'b0);
                    if (!locked && prev_locked) match_ev(EV_UNLOCK, int'(cyc_cnt), 1'b1);
                    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                        checks++;
                        failures++;
                        $display("FAIL missed_%s cyc=%0d: DUT showed nothing, required event at cyc=%0d",
                                 ev_name(exp_q[0].kind), cyc, exp_q[0].cyc);
                        void'(exp_q.pop_front());
                    end
                end
                prev_locked = locked;
            end
        end
    end

    // Stimulus.
    initial begin : driver
        rst     = 1'b1;
        clk_cpu = 1'b0;
        do_reset(3, 1'b0);

        // Lock with an 8-clk period, then run long enough to wrap the 4-bit counter.
        periods(24, 4);
        rand_periods(30);

        // A long stall drops the lock; resuming relocks.
        hold_level(1'b0, 70);
        periods(14, 4);

        // Stalls straddling the watchdog limit, starting from either level.
        for (int i = 0; i < 8; i++) begin
            hold_level(1'($urandom_range(0, 1)), $urandom_range(TIMEOUT - 6, TIMEOUT + 6));
            rand_periods(12);
        end

        // Reset in the middle of HOLD, with clk_cpu high at reset release.
        do_reset(2, 1'b0);
        for (int k = 0; k < 200 && !(phase == 1 && rises == 3); k++) begin
            step(1'(((k / 4) % 2) == 0), 1'b0);
        end
        do_reset(1, 1'b1);
        periods(14, 4);

        // Random mix of runs, stalls and resets.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0: do_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
                1: hold_level(1'($urandom_range(0, 1)), $urandom_range(TIMEOUT - 4, TIMEOUT + 20));
                default: rand_periods(8);
            endcase
        end
        hold_level(1'b0, 4);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected events left unmatched, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
